divider_regfile: RTL and testbench



---
 rtl/divider_regfile.sv | 38 +++
 tb/tb_divider_regfile.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/divider_regfile.sv
// Three-port register file: two combinational read ports, one synchronous write port; x0 reads as zero.
// Latency: reads are zero-cycle, a write becomes visible after the rising clk edge that captures it.
// Backpressure: none; always ready, with no write-to-read bypass (forwarding is handled by the pipeline).
module divider_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [AW-1:0]   wa3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];

    // Entry 0 is cleared by reset and never written, so it stays constant zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != '0)) begin
            regs[wa3] <= wd3;
        end
    end

    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs[ra1];
        rd2 = (ra2 == '0) ? '0 : regs[ra2];
    end

endmodule

// File: tb/tb_divider_regfile.sv
// Bench for divider_regfile: directed vector table, hand-written reset sequence, random traffic vs. an array model.
module tb_divider_regfile;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [31:0] wd3;
    logic [31:0] rd1, rd2;

    int vectors;
    int miscompares;

    divider_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [11];

    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Expected values are the read data seen just before the edge that performs the row's write.
        tbl[0]  = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd3,  32'h00000000, 32'h00000000};
        tbl[1]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd3,  5'd3,  32'h12345678, 32'h12345678};
        tbl[2]  = '{1'b1, 5'd0,  32'hA5A5A5A5, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h00000000};
        tbl[3]  = '{1'b1, 5'd7,  32'h11111111, 5'd0,  5'd31, 32'h00000000, 32'hFFFFFFFF};
        tbl[4]  = '{1'b0, 5'd7,  32'h22222222, 5'd7,  5'd0,  32'h11111111, 32'h00000000};
        tbl[5]  = '{1'b1, 5'd4,  32'h0000000A, 5'd7,  5'd4,  32'h11111111, 32'h00000000};
        tbl[6]  = '{1'b1, 5'd4,  32'h0000000B, 5'd4,  5'd4,  32'h0000000A, 32'h0000000A};
        tbl[7]  = '{1'b1, 5'd1,  32'h00000001, 5'd4,  5'd7,  32'h0000000B, 32'h11111111};
        tbl[8]  = '{1'b1, 5'd2,  32'h00000002, 5'd1,  5'd0,  32'h00000001, 32'h00000000};
        tbl[9]  = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd2,  32'h00000001, 32'h00000002};
        tbl[10] = '{1'b0, 5'd0,  32'h00000000, 5'd2,  5'd1,  32'h00000002, 32'h00000001};

        reset = 1'b1;
        we3   = 1'b0;
        wa3   = '0;
        wd3   = '0;
        ra1   = 5'd5;
        ra2   = 5'd31;
        #2;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we3 = tbl[i].we;
            wa3 = tbl[i].wa;
            wd3 = tbl[i].wd;
            ra1 = tbl[i].a1;
            ra2 = tbl[i].a2;
            #1;
            chk($sformatf("tbl%0d_rd1", i), rd1, tbl[i].e1);
            chk($sformatf("tbl%0d_rd2", i), rd2, tbl[i].e2);
        end
        @(negedge clk);
        we3 = 1'b0;
        ra1 = 5'd4;
        #1;
        chk("rdw_after_edge", rd1, 32'h0000000B);

        // Asynchronous reset mid-cycle, writes blocked while held, release mid-cycle.
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd5;
        wd3 = 32'hDEADBEEF;
        ra1 = 5'd5;
        @(posedge clk);
        #2;
        we3 = 1'b0;
        chk("pre_reset_rd1", rd1, 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        chk("async_clear_rd1", rd1, 32'h0);
        we3 = 1'b1;
        wa3 = 5'd9;
        wd3 = 32'hCAFEF00D;
        ra2 = 5'd9;
        @(posedge clk);
        #1;
        chk("write_in_reset", rd2, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("no_write_on_release", rd2, 32'h0);
        we3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = i[4:0];
            #1;
            chk($sformatf("cleared_r%0d", i), rd1, 32'h0);
        end
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd9;
        wd3 = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        chk("first_write_after_release", rd2, 32'hCAFEF00D);

        // Random traffic against an array model, starting from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom_range(0, 31));
            wd3 = $urandom;
            ra1 = 5'($urandom_range(0, 31));
            ra2 = (n % 5 == 0) ? wa3 : 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("rnd%0d_rd1", n), rd1, model[ra1]);
            chk($sformatf("rnd%0d_rd2", n), rd2, model[ra2]);
            @(posedge clk);
            if (we3 && wa3 != 5'd0) model[wa3] = wd3;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
